// File: rtl/ysyx_22050612_ifu.sv
// ysyx_22050612 IFU: owns the PC, keeps one imem fetch outstanding, buffers one inst.
// Optional ebreak halt: define YSYX_22050612_IFU_EBREAK_HALT_EN.
module ysyx_22050612_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        halted
);

  typedef enum logic {REQ, WAIT} state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] fetch_pc_q, fetch_pc_d;
  logic [63:0] inst_pc_q, inst_pc_d;
  logic [31:0] inst_q, inst_d;
  logic        discard_q, discard_d;
  logic        buf_valid_q, buf_valid_d;
  logic        halted_q, halted_d;
  logic        run_q, run_d;
  logic        req_fire;
  logic        resp_take;
  logic        halt_hit;

  // run_q keeps the request low for the cycle in which reset is held
  assign imem_req_valid = run_q && (state_q == REQ)
                          && !buf_valid_q && !halted_q;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = buf_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign halted         = halted_q;

  assign req_fire  = imem_req_valid && imem_req_ready;
  assign resp_take = (state_q == WAIT) && imem_resp_valid
                     && !discard_q && !redirect_valid;

`ifdef YSYX_22050612_IFU_EBREAK_HALT_EN
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  assign halt_hit = resp_take && (imem_resp_data == EBREAK);
`else
  assign halt_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_pc_d  = fetch_pc_q;
    inst_pc_d   = inst_pc_q;
    inst_d      = inst_q;
    discard_d   = discard_q;
    buf_valid_d = buf_valid_q;
    halted_d    = halted_q;
    run_d       = 1'b1;

    if (buf_valid_q && inst_ready) buf_valid_d = 1'b0;

    unique case (state_q)
      REQ: begin
        if (req_fire) begin
          fetch_pc_d = pc_q;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          state_d   = REQ;
          discard_d = 1'b0;
        end
      end
      default: ;
    endcase

    if (resp_take) begin
      buf_valid_d = 1'b1;
      inst_d      = imem_resp_data;
      inst_pc_d   = fetch_pc_q;
      pc_d        = fetch_pc_q + 64'd4;
    end

    if (halt_hit) halted_d = 1'b1;

    // a response landing in the redirect cycle closes the old fetch itself
    if (redirect_valid) begin
      pc_d        = {redirect_pc[63:2], 2'b00};
      buf_valid_d = 1'b0;
      if (((state_q == WAIT) && !imem_resp_valid) || req_fire)
        discard_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      fetch_pc_q  <= 64'd0;
      inst_pc_q   <= 64'd0;
      inst_q      <= 32'd0;
      discard_q   <= 1'b0;
      buf_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_pc_q  <= fetch_pc_d;
      inst_pc_q   <= inst_pc_d;
      inst_q      <= inst_d;
      discard_q   <= discard_d;
      buf_valid_q <= buf_valid_d;
      halted_q    <= halted_d;
      run_q       <= run_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// Randomized bench for ysyx_22050612_ifu against a PC-stream reference model.
// Memory model answers each accepted fetch once, after a random latency.
module tb_ysyx_22050612_ifu;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'd0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic        halted;

  always #5 clk = ~clk;

  ysyx_22050612_ifu #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // stimulus knobs
  int rdy_pct, irdy_pct, redir_pct, lat_min, lat_max;
  bit force_rdy, force_redir;
  logic [63:0] force_tgt;

  // memory model
  bit          mem_busy;
  int          mem_cnt;
  logic [63:0] mem_addr;
  logic [63:0] ebreak_addr = 64'h1;

  // reference model and bookkeeping
  logic [63:0] exp_pc, redir_tgt, hold_pc;
  logic [31:0] hold_inst;
  bit          chk_redir, chk_fire, hold_chk;
  int          ndel, nfire, cyc;
  int          fire_cyc[$];
  logic [63:0] fire_addr[$];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == ebreak_addr) return 32'h0010_0073;
    return a[31:0] ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [63:0] rand_tgt();
    if ($urandom_range(0, 9) == 0)
      return 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
    return RESET_PC + 64'($urandom_range(0, 1023));
  endfunction

  // called at a negedge: check outputs, pick inputs, record the next edge
  task automatic step();
    bit fire, hs;
    if (chk_redir) begin
      chk("redir_inst_valid", inst_valid, 0);
      chk("redir_req_addr", imem_req_addr, redir_tgt);
      chk_redir = 0;
    end
    if (hold_chk) begin
      chk("hold_valid", inst_valid, 1);
      chk("hold_inst", inst, hold_inst);
      chk("hold_pc", inst_pc, hold_pc);
    end
    if (inst_valid) chk("no_req_while_full", imem_req_valid, 0);
    if (mem_busy) chk("one_outstanding", imem_req_valid, 0);

    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    if (mem_busy) begin
      if (mem_cnt == 1) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mem_addr);
        mem_busy = 0;
      end else begin
        mem_cnt--;
      end
    end
    imem_req_ready = force_rdy || ($urandom_range(0, 99) < rdy_pct);
    inst_ready = ($urandom_range(0, 99) < irdy_pct);
    redirect_valid = 1'b0;
    if (force_redir) begin
      redirect_valid = 1'b1;
      redirect_pc = force_tgt;
    end else if ($urandom_range(0, 99) < redir_pct) begin
      redirect_valid = 1'b1;
      redirect_pc = rand_tgt();
    end
    force_rdy = 0;
    force_redir = 0;

    fire = imem_req_valid && imem_req_ready;
    if (fire) begin
      mem_busy = 1;
      mem_cnt = $urandom_range(lat_min, lat_max);
      mem_addr = imem_req_addr;
      nfire++;
      fire_cyc.push_back(cyc);
      fire_addr.push_back(imem_req_addr);
      if (chk_fire) begin
        chk("first_fetch_addr", imem_req_addr, redir_tgt);
        chk_fire = 0;
      end
    end
    hs = inst_valid && inst_ready;
    if (hs) begin
      chk("inst_pc", inst_pc, exp_pc);
      chk("inst", inst, mem_word(exp_pc));
      exp_pc += 64'd4;
      ndel++;
    end
    if (redirect_valid) begin
      exp_pc = {redirect_pc[63:2], 2'b00};
      redir_tgt = exp_pc;
      chk_redir = 1;
      chk_fire = 1;
    end
    hold_chk = inst_valid && !inst_ready && !redirect_valid;
    hold_inst = inst;
    hold_pc = inst_pc;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic knobs(input int rp, input int ip, input int dp,
                       input int lmin, input int lmax);
    rdy_pct = rp; irdy_pct = ip; redir_pct = dp;
    lat_min = lmin; lat_max = lmax;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'd0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 64'd0;
    mem_busy = 0;
    chk_redir = 0;
    chk_fire = 0;
    hold_chk = 0;
    force_rdy = 0;
    force_redir = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_halted", halted, 0);
    rst_n = 1'b1;
    exp_pc = RESET_PC;
    redir_tgt = RESET_PC;
    chk_fire = 1;
    ndel = 0;
    nfire = 0;
    fire_cyc.delete();
    fire_addr.delete();
  endtask

  initial begin
    cyc = 0;
    knobs(100, 100, 0, 1, 1);

    // throughput: 1-cycle memory, always ready
    do_reset();
    begin
      int k = 0;
      while (nfire < 3 && k < 40) begin step(); k++; end
    end
    chk("tp_nfire", nfire, 3);
    if (fire_cyc.size() == 3) begin
      chk("tp_gap1", fire_cyc[1] - fire_cyc[0], 3);
      chk("tp_gap2", fire_cyc[2] - fire_cyc[1], 3);
      chk("tp_addr0", fire_addr[0], RESET_PC);
      chk("tp_addr1", fire_addr[1], RESET_PC + 64'd4);
      chk("tp_addr2", fire_addr[2], RESET_PC + 64'd8);
    end

    // IDU stall for 5 cycles
    do_reset();
    knobs(100, 0, 0, 1, 1);
    begin
      int k = 0;
      while (!inst_valid && k < 20) begin step(); k++; end
    end
    chk("stall_got_inst", inst_valid, 1);
    run(5);
    chk("stall_no_req", imem_req_valid, 0);
    chk("stall_pc", inst_pc, RESET_PC);
    irdy_pct = 100;
    step();
    chk("req_after_drain", imem_req_valid, 1);
    chk("req_after_drain_addr", imem_req_addr, RESET_PC + 64'd4);

    // redirect while waiting on a slow response
    do_reset();
    knobs(100, 100, 0, 3, 3);
    begin
      int k = 0;
      while (!mem_busy && k < 20) begin step(); k++; end
    end
    chk("wait_reached", mem_busy, 1);
    force_redir = 1;
    force_tgt = 64'h8000_0102;
    step();
    lat_min = 1; lat_max = 1;
    run(30);
    chk("redir_wait_progress", ndel >= 3, 1);

    // redirect in the cycle the request is accepted
    do_reset();
    knobs(0, 100, 0, 1, 1);
    begin
      int k = 0;
      while (!imem_req_valid && k < 20) begin step(); k++; end
    end
    chk("samecyc_req_seen", imem_req_valid, 1);
    force_rdy = 1;
    force_redir = 1;
    force_tgt = 64'h8000_0200;
    step();
    chk("samecyc_fired", nfire, 1);
    rdy_pct = 100;
    run(30);
    chk("samecyc_progress", ndel >= 3, 1);

    // PC wrap at the top of the address space
    do_reset();
    knobs(100, 100, 0, 1, 2);
    force_redir = 1;
    force_tgt = 64'hFFFF_FFFF_FFFF_FFFC;
    begin
      int k = 0;
      while (ndel < 2 && k < 40) begin step(); k++; end
    end
    chk("wrap_deliveries", ndel >= 2, 1);

    // ebreak at RESET_PC+8
    do_reset();
    knobs(100, 100, 0, 1, 1);
    ebreak_addr = RESET_PC + 64'd8;
    run(30);
`ifdef YSYX_22050612_IFU_EBREAK_HALT_EN
    chk("halt_flag", halted, 1);
    chk("halt_ndel", ndel, 3);
    chk("halt_nfire", nfire, 3);
    chk("halt_no_req", imem_req_valid, 0);
`else
    chk("nohalt_flag", halted, 0);
    chk("nohalt_continues", ndel >= 4, 1);
`endif
    ebreak_addr = 64'h1;

    // random traffic with a reset in the middle
    do_reset();
    knobs(70, 60, 4, 1, 4);
    run(1500);
    do_reset();
    knobs(70, 60, 4, 1, 4);
    run(1500);
    chk("rand_progress", ndel > 50, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22050612_ifu.md
# ysyx_22050612_ifu

Instruction fetch unit for the ysyx_22050612 core. Owns the program counter, issues one 32-bit fetch at a time to the instruction memory port, and hands each fetched instruction, with its PC, to the decode stage (IDU) over a valid/ready interface. It accepts a redirect (jump/branch target) from execute, squashes any in-flight fetch, and restarts from the new PC.

## Interface
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  64  fetch address, equals current PC
- imem_resp_valid  in  1  response data valid, single-cycle pulse
- imem_resp_data  in  32  fetched instruction word
- inst_valid  out  1  instruction available to IDU
- inst_ready  in  1  IDU consumes instruction this cycle
- inst  out  32  instruction to IDU
- inst_pc  out  64  PC of `inst`
- redirect_valid  in  1  load new PC, flush fetch
- redirect_pc  in  64  redirect target
- halted  out  1  fetch stopped on ebreak; constant 0 when the halt feature is compiled out

## Operation
- State machine: REQ, WAIT. Registers: pc, fetch_pc, discard, 1-entry output buffer (buf_valid, inst, inst_pc), halted.
- REQ: imem_req_valid = !buf_valid && !halted (registered terms only); imem_req_addr = pc. On imem_req_valid && imem_req_ready: fetch_pc <= pc, go WAIT.
- WAIT: at most one request outstanding. On imem_resp_valid: if discard, drop data, clear discard; else buffer <= {data, fetch_pc}, buf_valid <= 1, pc <= fetch_pc + 4 (64-bit, wraps mod 2^64). Go REQ in both cases.
- imem_resp_valid outside WAIT is ignored.
- Output: inst_valid = buf_valid. On inst_valid && inst_ready, buf_valid <= 0.
- Redirect (highest priority): pc <= {redirect_pc[63:2], 2'b00}; buf_valid <= 0. If state is WAIT, or a request is accepted this same cycle, discard <= 1. A response arriving in the redirect cycle is dropped and does not update pc.
- Redirect coincident with an inst_valid && inst_ready handshake: handshake counts as completed; buffer cleared.
- Reset mid-fetch: state REQ, discard 0, buf_valid 0, pc = RESET_PC. Memory is required to drop its outstanding response on the same reset.

## Timing
- Reset values: imem_req_valid 0 during reset cycle, 1 from first cycle after rst_n rises; imem_req_addr = RESET_PC; inst_valid 0; inst 0; inst_pc 0; halted 0.
- Response accepted in cycle N: inst_valid high in N+1, inst_pc = fetch_pc.
- Next request earliest in the cycle after the buffer drains; peak throughput 1 instruction per 3 cycles with a 1-cycle memory.
- Redirect in cycle N: inst_valid 0 and imem_req_addr = new PC in N+1. The request is issued in N+1 if REQ and not blocked. If the redirect hit WAIT, the new request waits for the stale response to be discarded.
- inst/inst_pc hold stable while inst_valid && !inst_ready.

## Configuration
- Macro YSYX_22050612_IFU_EBREAK_HALT_EN.
- Defined: when a non-discarded response equals 32'h0010_0073 (ebreak), it is buffered and delivered normally. halted <= 1 in the same edge, and no further requests are issued. Redirect does not clear halted; only reset does.
- Undefined: ebreak is fetched like any other instruction, fetching continues, and halted is tied 0.

## Test plan
- Reset release with RESET_PC=0x8000_0000, 1-cycle memory, inst_ready=1 -> requests at 0x8000_0000, 0x8000_0004, 0x8000_0008; inst_pc matches; 3-cycle spacing.
- inst_ready held 0 for 5 cycles after first instruction -> inst/inst_pc stable, imem_req_valid 0 throughout; next request the cycle after inst_ready=1.
- Redirect to 0x8000_0102 while in WAIT -> stale response dropped, inst_valid stays 0, next request addr 0x8000_0100, first delivered inst_pc 0x8000_0100.
- Redirect in the same cycle as imem_req_ready -> that response discarded; next fetch from redirect target only.
- pc = 0xFFFF_FFFF_FFFF_FFFC fetch -> following request addr 0x0.
- With YSYX_22050612_IFU_EBREAK_HALT_EN, memory returns 0x0010_0073 at 0x8000_0008 -> ebreak delivered with inst_pc 0x8000_0008, halted=1 next cycle, no further imem_req_valid; without the macro, fetch continues to 0x8000_000C.
